// File: rtl/psum_drain_if.sv
// Read port toward the psum buffer plus the requantized output stream.
// master = drain stage, slave = buffer/writeback side.
interface psum_drain_if #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_WIDTH  = 8
);
    logic                           rd_en;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] rd_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [ARRAY_DIM*OUT_WIDTH-1:0] out_data;
    logic                           out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/psum_drain.sv
// Drains a tile of partial sums from the psum buffer, requantizes each lane
// and streams rows downstream through a 3-entry FIFO with valid/ready.
module psum_drain #(
    parameter int ARRAY_DIM   = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    num_rows,
    input  logic [SHIFT_WIDTH-1:0] shift_amt,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    psum_drain_if.master           bus
);
    localparam int ROW_W = ARRAY_DIM * OUT_WIDTH;
    localparam int XW    = ACC_WIDTH + 1;
    localparam logic signed [XW-1:0] SAT_MAX = XW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = XW'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [ADDR_WIDTH:0]    rows_reg;
    logic [ADDR_WIDTH:0]    issued_reg;
    logic [SHIFT_WIDTH-1:0] shift_reg;
    logic                   relu_reg;
    logic                   zero_arm_reg;
    logic                   inflight_reg;
    logic                   rd_last_reg;
    logic                   last_sent_reg;
    logic [1:0]             count_reg;
    logic [1:0]             wr_ptr_reg;
    logic [1:0]             rd_ptr_reg;
    logic [ROW_W-1:0]       fifo_data [0:2];
    logic                   fifo_last [0:2];
    logic [ROW_W-1:0]       req_data;

    logic head_valid, issue, last_issue, push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit check uses only registered state, so out_ready never reaches rd_en.
    assign head_valid = (count_reg != 2'd0);
    assign issue      = (state_reg == READ) &&
                        (({1'b0, count_reg} + {2'b0, inflight_reg}) < 3'd3);
    assign last_issue = issue && (issued_reg == rows_reg - 1'b1);
    assign push       = inflight_reg;
    assign pop        = head_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (num_rows == '0) ? DONE : READ;
            READ:    if (last_issue) state_next = FLUSH;
            FLUSH:   if (!inflight_reg && (count_reg == 2'd0) && last_sent_reg)
                         state_next = DONE;
            DONE:    if (!zero_arm_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An empty drain spends its first DONE cycle armed (silent) so that
    // busy and done both land two cycles after start.
    always_comb begin
        busy          = (state_reg != IDLE) && !zero_arm_reg;
        done          = (state_reg == DONE) && !zero_arm_reg;
        bus.rd_en     = issue;
        bus.rd_addr   = addr_reg;
        bus.out_valid = head_valid;
        bus.out_data  = head_valid ? fifo_data[rd_ptr_reg] : '0;
        bus.out_last  = head_valid && fifo_last[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            rows_reg      <= '0;
            issued_reg    <= '0;
            shift_reg     <= '0;
            relu_reg      <= 1'b0;
            zero_arm_reg  <= 1'b0;
            inflight_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            last_sent_reg <= 1'b0;
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 2'd0;
            rd_ptr_reg    <= 2'd0;
        end else begin
            if ((state_reg == IDLE) && start) begin
                addr_reg      <= base_addr;
                rows_reg      <= num_rows;
                issued_reg    <= '0;
                shift_reg     <= shift_amt;
                relu_reg      <= relu_en;
                last_sent_reg <= 1'b0;
                zero_arm_reg  <= (num_rows == '0);
            end else if (state_reg == DONE) begin
                zero_arm_reg <= 1'b0;
            end
            if (issue) begin
                addr_reg   <= addr_reg + 1'b1;
                issued_reg <= issued_reg + 1'b1;
            end
            inflight_reg <= issue;
            rd_last_reg  <= last_issue;
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                if (fifo_last[rd_ptr_reg]) last_sent_reg <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= req_data;
            fifo_last[wr_ptr_reg] <= rd_last_reg;
        end
    end

    // One extra bit of headroom keeps the rounding add from overflowing.
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
            logic signed [XW-1:0]        x_ext;
            logic signed [XW-1:0]        rnd;
            logic signed [XW-1:0]        shifted;
            logic        [OUT_WIDTH-1:0] lane_out;

            always_comb begin
                x_ext = XW'(signed'(bus.rd_data[gi*ACC_WIDTH +: ACC_WIDTH]));
                rnd   = '0;
                if (shift_reg != '0) rnd = XW'(1) << (shift_reg - 1'b1);
                shifted = (x_ext + rnd) >>> shift_reg;
                if (relu_reg && (shifted < 0)) shifted = '0;
                if (shifted > SAT_MAX)      lane_out = SAT_MAX[OUT_WIDTH-1:0];
                else if (shifted < SAT_MIN) lane_out = SAT_MIN[OUT_WIDTH-1:0];
                else                        lane_out = shifted[OUT_WIDTH-1:0];
            end

            assign req_data[gi*OUT_WIDTH +: OUT_WIDTH] = lane_out;
        end
    endgenerate
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: buffer read model, stream monitor and
// table-driven requant vectors plus hand-written multi-cycle sequences.
module tb_psum_drain;
    localparam int AD  = 16;
    localparam int AW  = 32;
    localparam int ADW = 10;
    localparam int OW  = 8;
    localparam int SW  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [ADW-1:0] base_addr;
    logic [ADW:0]   num_rows;
    logic [SW-1:0]  shift_amt;
    logic           relu_en;
    logic           busy;
    logic           done;

    psum_drain_if bus_if ();

    psum_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .shift_amt (shift_amt),
        .relu_en   (relu_en),
        .busy      (busy),
        .done      (done),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- buffer read model ----------------
    logic [AD*AW-1:0] mem [0:1023];
    logic             pend = 1'b0;
    logic [ADW-1:0]   pend_addr = '0;

    always @(negedge clk) begin
        pend      <= bus_if.rd_en;
        pend_addr <= bus_if.rd_addr;
    end

    initial begin
        bus_if.rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.rd_data = pend ? mem[pend_addr] : {AD{32'hDEADBEEF}};
        end
    end

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;
    initial begin
        int stall_left;
        int prev_mode;
        stall_left = 0;
        prev_mode  = 0;
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0) begin
                bus_if.out_ready = 1'b1;
            end else if (prev_mode == 0) begin
                bus_if.out_ready = 1'b0;
                stall_left = 4;
            end else if (stall_left > 0) begin
                bus_if.out_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 5) == 0) begin
                bus_if.out_ready = 1'b0;
                stall_left = 4;
            end else begin
                bus_if.out_ready = 1'($urandom_range(0, 1));
            end
            prev_mode = ready_mode;
        end
    end

    // ---------------- stream monitor ----------------
    typedef struct {
        logic [AD*OW-1:0] data;
        logic             last;
        int               cyc;
    } beat_t;

    beat_t            beat_q [$];
    int               rd_addr_q [$];
    int               rd_cyc_q [$];
    int               done_q [$];
    int               stall_err = 0;
    logic             prev_stall = 1'b0;
    logic [AD*OW-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus_if.rd_en) begin
                rd_addr_q.push_back(int'(bus_if.rd_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (done) done_q.push_back(cyc);
            if (prev_stall && (!bus_if.out_valid || bus_if.out_data != prev_data ||
                               bus_if.out_last != prev_last))
                stall_err <= stall_err + 1;
            if (bus_if.out_valid && bus_if.out_ready)
                beat_q.push_back('{data: bus_if.out_data, last: bus_if.out_last, cyc: cyc});
            prev_stall <= bus_if.out_valid && !bus_if.out_ready;
            prev_data  <= bus_if.out_data;
            prev_last  <= bus_if.out_last;
        end
    end

    // ---------------- helpers ----------------
    logic busy_hist [0:63];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [AD*OW-1:0] act,
                           input logic [AD*OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AD*OW-1:0] exp_row(input int a);
        logic [AD*OW-1:0] r;
        for (int l = 0; l < AD; l++) r[l*OW +: OW] = mem[a][l*AW +: OW];
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
        chk({tag, "_rd_en"},     bus_if.rd_en, 0);
        chk({tag, "_rd_addr"},   bus_if.rd_addr, 0);
        chk({tag, "_out_valid"}, bus_if.out_valid, 0);
        chk_vec({tag, "_out_data"}, bus_if.out_data, '0);
        chk({tag, "_out_last"},  bus_if.out_last, 0);
    endtask

    task automatic run_drain(input int base, input int n, input int sh, input bit rl,
                             input int inject_at, output int c0, output int rd_base,
                             output int beat_base, output int rel_done, output bit occ_bad);
        int done_base;
        base_addr = ADW'(base);
        num_rows  = (ADW+1)'(n);
        shift_amt = SW'(sh);
        relu_en   = rl;
        start     = 1'b1;
        c0        = cyc;
        rd_base   = rd_addr_q.size();
        beat_base = beat_q.size();
        done_base = done_q.size();
        rel_done  = -1;
        occ_bad   = 1'b0;
        for (int i = 0; i < 64; i++) busy_hist[i] = 1'b0;
        for (int t = 0; t < 600 && rel_done < 0; t++) begin
            tick();
            start = 1'b0;
            if (cyc - c0 == inject_at) begin
                start     = 1'b1;
                base_addr = ADW'(500);
                num_rows  = (ADW+1)'(2);
                shift_amt = SW'(3);
                relu_en   = 1'b1;
            end
            if (cyc - c0 < 64) busy_hist[cyc - c0] = busy;
            if ((rd_addr_q.size() - rd_base) - (beat_q.size() - beat_base) > 4) occ_bad = 1'b1;
            if (done_q.size() > done_base) rel_done = done_q[done_base] - c0;
        end
        start = 1'b0;
        chk("drain_completes", (rel_done >= 0) ? 1 : 0, 1);
    endtask

    task automatic check_rows(input string nm, input int base, input int n, input int rd_base,
                              input int beat_base, input int c0, input bit timing);
        chk({nm, "_reads"}, rd_addr_q.size() - rd_base, n);
        chk({nm, "_beats"}, beat_q.size() - beat_base, n);
        for (int k = 0; k < n; k++) begin
            if (rd_base + k < rd_addr_q.size())
                chk($sformatf("%s_addr%0d", nm, k), rd_addr_q[rd_base + k], (base + k) % 1024);
            if (beat_base + k < beat_q.size()) begin
                chk_vec($sformatf("%s_data%0d", nm, k), beat_q[beat_base + k].data,
                        exp_row((base + k) % 1024));
                chk($sformatf("%s_last%0d", nm, k), beat_q[beat_base + k].last, (k == n - 1) ? 1 : 0);
                if (timing)
                    chk($sformatf("%s_beat_cyc%0d", nm, k), beat_q[beat_base + k].cyc - c0, 3 + k);
            end
        end
    endtask

    typedef struct {
        int val;
        int sh;
        bit rl;
        int exp;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0, rb, bb, rel_done, db, rq;
        bit occ_bad, ok;
        int basic_vals [4];
        logic [AD*OW-1:0] e;

        basic_vals = '{5, -3, 127, -128};
        vecs = '{
            '{5, 0, 1'b0, 5},      '{-3, 0, 1'b0, -3},     '{127, 0, 1'b0, 127},
            '{-128, 0, 1'b0, -128}, '{200, 0, 1'b0, 127},  '{-129, 0, 1'b0, -128},
            '{24, 4, 1'b0, 2},     '{23, 4, 1'b0, 1},      '{-24, 4, 1'b0, -1},
            '{40000, 4, 1'b0, 127}, '{-40000, 4, 1'b0, -128},
            '{24, 4, 1'b1, 2},     '{23, 4, 1'b1, 1},      '{-24, 4, 1'b1, 0},
            '{40000, 4, 1'b1, 127}, '{-40000, 4, 1'b1, 0},
            '{8, 4, 1'b0, 1},      '{-8, 4, 1'b0, 0},      '{-9, 4, 1'b0, -1},
            '{5, 1, 1'b0, 3},      '{-5, 1, 1'b0, -2},
            '{32'sh7FFFFFFF, 31, 1'b0, 1}, '{32'sh80000000, 31, 1'b0, -1}
        };

        for (int a = 0; a < 1024; a++)
            for (int l = 0; l < AD; l++)
                mem[a][l*AW +: AW] = 32'(signed'(8'(a * 7 + l * 13 + 3)));
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < AD; l++)
                mem[k][l*AW +: AW] = 32'(basic_vals[(l + k) % 4]);

        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; shift_amt = '0; relu_en = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // basic drain with exact latency
        run_drain(0, 4, 0, 1'b0, -1, c0, rb, bb, rel_done, occ_bad);
        check_rows("basic", 0, 4, rb, bb, c0, 1'b1);
        chk("basic_done_cyc", rel_done, 8);
        if (rd_cyc_q.size() > rb) chk("basic_first_rd_cyc", rd_cyc_q[rb] - c0, 1);
        ok = 1'b1;
        for (int r = 1; r <= 8; r++) if (!busy_hist[r]) ok = 1'b0;
        chk("basic_busy_window", ok, 1);
        tick();
        chk("basic_busy_after_done", busy, 0);

        // zero rows
        run_drain(5, 0, 0, 1'b0, -1, c0, rb, bb, rel_done, occ_bad);
        chk("zero_done_cyc", rel_done, 2);
        chk("zero_reads", rd_addr_q.size() - rb, 0);
        chk("zero_beats", beat_q.size() - bb, 0);
        chk("zero_busy_c1", busy_hist[1], 0);
        chk("zero_busy_c2", busy_hist[2], 1);
        tick();
        chk("zero_busy_c3", busy, 0);

        // address wrap
        run_drain(1022, 4, 0, 1'b0, -1, c0, rb, bb, rel_done, occ_bad);
        check_rows("wrap", 1022, 4, rb, bb, c0, 1'b1);
        tick();

        // random backpressure with 5-cycle stall stretches
        ready_mode = 1;
        run_drain(40, 8, 0, 1'b0, -1, c0, rb, bb, rel_done, occ_bad);
        check_rows("bp", 40, 8, rb, bb, c0, 1'b0);
        chk("bp_occupancy_ok", occ_bad ? 0 : 1, 1);
        chk("bp_stable_under_stall", stall_err, 0);
        ready_mode = 0;
        repeat (2) tick();

        // second start during a drain is ignored
        run_drain(200, 6, 0, 1'b0, 3, c0, rb, bb, rel_done, occ_bad);
        check_rows("busystart", 200, 6, rb, bb, c0, 1'b1);
        chk("busystart_done_cyc", rel_done, 10);
        repeat (3) tick();
        chk("busystart_no_extra_reads", rd_addr_q.size() - rb, 6);

        // reset after two beats of a six-row drain
        base_addr = ADW'(300); num_rows = (ADW+1)'(6); shift_amt = '0; relu_en = 1'b0;
        start = 1'b1;
        bb = beat_q.size();
        db = done_q.size();
        for (int t = 0; t < 50 && (beat_q.size() - bb) < 2; t++) begin
            tick();
            start = 1'b0;
        end
        start = 1'b0;
        chk("rstmid_two_beats_seen", beat_q.size() - bb, 2);
        rst = 1'b1;
        rq = rd_addr_q.size();
        tick();
        check_outputs_zero("rstmid");
        rst = 1'b0;
        repeat (10) tick();
        chk("rstmid_no_done", done_q.size() - db, 0);
        chk("rstmid_no_more_beats", beat_q.size() - bb, 2);
        chk("rstmid_no_more_reads", rd_addr_q.size() - rq, 0);
        if (beat_q.size() >= bb + 2) begin
            chk_vec("rstmid_beat0", beat_q[bb].data, exp_row(300));
            chk_vec("rstmid_beat1", beat_q[bb + 1].data, exp_row(301));
        end

        run_drain(400, 3, 0, 1'b0, -1, c0, rb, bb, rel_done, occ_bad);
        check_rows("afterrst", 400, 3, rb, bb, c0, 1'b1);
        chk("afterrst_done_cyc", rel_done, 7);
        tick();

        // requant table, one single-row drain per vector
        for (int i = 0; i < vecs.size(); i++) begin
            int lane;
            lane = i % AD;
            mem[100] = '0;
            mem[100][lane*AW +: AW] = 32'(vecs[i].val);
            e = '0;
            e[lane*OW +: OW] = 8'(vecs[i].exp);
            run_drain(100, 1, vecs[i].sh, vecs[i].rl, -1, c0, rb, bb, rel_done, occ_bad);
            if (beat_q.size() > bb)
                chk_vec($sformatf("requant%0d_v%0d_s%0d_r%0d", i, vecs[i].val, vecs[i].sh, vecs[i].rl),
                        beat_q[bb].data, e);
            else
                chk($sformatf("requant%0d_beat_present", i), beat_q.size() - bb, 1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
